// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: receiver FSM encoding and default bit timing.
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 234;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Read-side bundle of the UART receiver: FIFO head/handshake, occupancy and sticky error flags.
interface uart_rx_fifo_if #(
  parameter int FIFO_DEPTH = 16
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic [CNT_W-1:0] rx_count;
  logic             frame_err;
  logic             overrun;
  logic             err_clr;

  modport master (
    output rx_data, rx_valid, rx_count, frame_err, overrun,
    input  rx_ready, err_clr
  );

  modport slave (
    input  rx_data, rx_valid, rx_count, frame_err, overrun,
    output rx_ready, err_clr
  );

endinterface

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Show-ahead synchronous FIFO; a push while full is accepted only if a pop happens in the same cycle.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             pop_ok;
  logic             push_ok;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count   = wr_ptr_q - rd_ptr_q;
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push_ok) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with input synchroniser, false-start rejection, framing/overrun flags
// and a byte FIFO on a valid/ready read port.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | line idle high, waiting for a falling edge
// ST_START | timing to mid start bit; high there means a glitch
// ST_DATA  | sampling 8 data bits LSB first at each bit-period expiry
// ST_STOP  | sampling stop bit; high pushes the byte, low flags framing
// ST_BREAK | line held low after a framing error, wait for it to rise
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           uart_rx,
  uart_rx_fifo_if.master bus
);
  localparam int             CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  CNT_HALF  = CW'(CLKS_PER_BIT / 2 - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  rx_state_e              state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [2:0]             bit_q, bit_d;
  logic [7:0]             shift_q, shift_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d;

  logic                        rxs;
  logic                        push;
  logic                        pop;
  logic                        frame_set;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], uart_rx};
  assign rxs    = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    push      = 1'b0;
    frame_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!rxs) state_d = ST_START;
      end
      ST_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rxs ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rxs, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rxs) begin
            push    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            frame_set = 1'b1;
            state_d   = ST_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_BREAK: begin
        cnt_d = '0;
        if (rxs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Setting a flag wins over a same-cycle clear so no event is ever lost.
  assign pop         = ~fifo_empty & bus.rx_ready;
  assign frame_err_d = frame_set | (frame_err_q & ~bus.err_clr);
  assign overrun_d   = (push & fifo_full & ~pop) | (overrun_q & ~bus.err_clr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q      <= '1;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (shift_q),
    .pop       (pop),
    .rd_data   (bus.rx_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign bus.rx_valid  = ~fifo_empty;
  assign bus.rx_count  = fifo_count;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: vector table, hand-built corner sequences and
// random frames checked against a queue-based reference model.
module tb_uart_rx_fifo;
  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  localparam int SS    = 2;

  logic clk     = 1'b0;
  logic rst     = 1'b1;
  logic uart_rx = 1'b1;

  uart_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

  uart_rx_fifo #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH),
    .SYNC_STAGES  (SS)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .uart_rx (uart_rx),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [7:0] tx;
    int         period;
    logic [7:0] exp_data;
  } vec_t;

  vec_t       vecs [6];
  logic [7:0] model_q [$];
  logic       model_ovr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, 32'(bus.rx_valid), 0);
    check({tag, "_count"}, 32'(bus.rx_count), 0);
    check({tag, "_ferr"},  32'(bus.frame_err), 0);
    check({tag, "_ovr"},   32'(bus.overrun), 0);
  endtask

  // Start bit plus eight data bits, LSB first, each held for p clocks.
  task automatic drive_bits(input logic [7:0] d, input int p);
    uart_rx = 1'b0;
    repeat (p) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      repeat (p) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input int p);
    drive_bits(d, p);
    uart_rx = 1'b1;
    repeat (p) @(negedge clk);
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic pop_check(input string name, input logic [7:0] exp);
    check({name, "_valid"}, 32'(bus.rx_valid), 1);
    check({name, "_data"},  32'(bus.rx_data), 32'(exp));
    bus.rx_ready = 1'b1;
    @(negedge clk);
    bus.rx_ready = 1'b0;
  endtask

  task automatic pulse_err_clr();
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    int         npop;

    vecs[0] = '{8'h55, 16, 8'h55};
    vecs[1] = '{8'hA3, 16, 8'hA3};
    vecs[2] = '{8'h00, 16, 8'h00};
    vecs[3] = '{8'hFF, 16, 8'hFF};
    vecs[4] = '{8'hC5, 15, 8'hC5};
    vecs[5] = '{8'hC5, 17, 8'hC5};

    bus.rx_ready = 1'b0;
    bus.err_clr  = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    check("reset_data", 32'(bus.rx_data), 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Two bytes queued, then drained in order.
    send_frame(8'h55, CPB);
    send_frame(8'hA3, CPB);
    check("t1_count", 32'(bus.rx_count), 2);
    pop_check("t1_pop0", 8'h55);
    check("t1_count_after_pop", 32'(bus.rx_count), 1);
    pop_check("t1_pop1", 8'hA3);
    check("t1_empty", 32'(bus.rx_valid), 0);

    // Short low glitch must be rejected silently.
    uart_rx = 1'b0;
    repeat (5) @(negedge clk);
    uart_rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check_idle_outputs("t2");

    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].tx, vecs[i].period);
      check($sformatf("vec%0d_count", i), 32'(bus.rx_count), 1);
      check($sformatf("vec%0d_ferr", i),  32'(bus.frame_err), 0);
      pop_check($sformatf("vec%0d", i), vecs[i].exp_data);
    end

    // Stop bit held low for three bit times: one framing error, nothing stored.
    drive_bits(8'h3C, CPB);
    uart_rx = 1'b0;
    repeat (24) @(negedge clk);
    check("t3_ferr_set", 32'(bus.frame_err), 1);
    check("t3_count", 32'(bus.rx_count), 0);
    pulse_err_clr();
    repeat (10) @(negedge clk);
    check("t3_no_reflag_in_break", 32'(bus.frame_err), 0);
    repeat (13) @(negedge clk);
    uart_rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("t3_single_error", 32'(bus.frame_err), 0);
    send_frame(8'h7E, CPB);
    check("t3_next_count", 32'(bus.rx_count), 1);
    pop_check("t3_next", 8'h7E);

    // Overflow; err_clr lands on the same edge as the overrun and must lose.
    for (int i = 1; i <= 4; i++) send_frame(8'(i), CPB);
    fork
      send_frame(8'h05, CPB);
      begin
        repeat (154) @(negedge clk);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
      end
    join
    check("t4_count", 32'(bus.rx_count), 4);
    check("t4_ovr", 32'(bus.overrun), 1);
    for (int i = 1; i <= 4; i++) pop_check($sformatf("t4_pop%0d", i), 8'(i));
    check("t4_lost", 32'(bus.rx_valid), 0);
    check("t4_ovr_sticky", 32'(bus.overrun), 1);
    pulse_err_clr();
    check("t4_ovr_clr", 32'(bus.overrun), 0);

    // Same again, with a pop on the very edge of the fifth push.
    for (int i = 1; i <= 4; i++) send_frame(8'(i), CPB);
    fork
      send_frame(8'h05, CPB);
      begin
        repeat (154) @(negedge clk);
        bus.rx_ready = 1'b1;
        @(negedge clk);
        bus.rx_ready = 1'b0;
      end
    join
    check("t4b_count", 32'(bus.rx_count), 4);
    check("t4b_ovr", 32'(bus.overrun), 0);
    for (int i = 2; i <= 5; i++) pop_check($sformatf("t4b_pop%0d", i), 8'(i));
    check("t4b_empty", 32'(bus.rx_valid), 0);

    // Reset in the middle of a frame with a byte already waiting.
    send_frame(8'h99, CPB);
    check("t5_pre_count", 32'(bus.rx_count), 1);
    uart_rx = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    rst     = 1'b1;
    uart_rx = 1'b1;
    @(negedge clk);
    check_idle_outputs("t5_rst");
    check("t5_rst_data", 32'(bus.rx_data), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    check("t5_no_partial", 32'(bus.rx_valid), 0);
    send_frame(8'h81, CPB);
    check("t5_next_count", 32'(bus.rx_count), 1);
    pop_check("t5_next", 8'h81);

    // Both flags raised, then cleared by one err_clr pulse.
    for (int i = 0; i < 5; i++) send_frame(8'(8'h10 + i), CPB);
    drive_bits(8'h3C, CPB);
    uart_rx = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    uart_rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("t6_ferr", 32'(bus.frame_err), 1);
    check("t6_ovr", 32'(bus.overrun), 1);
    pulse_err_clr();
    check("t6_ferr_clr", 32'(bus.frame_err), 0);
    check("t6_ovr_clr", 32'(bus.overrun), 0);
    for (int i = 0; i < 4; i++) pop_check($sformatf("t6_pop%0d", i), 8'(8'h10 + i));

    // Random traffic against a plain queue model of the FIFO.
    model_q.delete();
    model_ovr = 1'b0;
    for (int it = 0; it < 24; it++) begin
      b = 8'($urandom);
      send_frame(b, CPB);
      if (model_q.size() < DEPTH) model_q.push_back(b);
      else model_ovr = 1'b1;
      check($sformatf("rnd%0d_count", it), 32'(bus.rx_count), 32'(model_q.size()));
      check($sformatf("rnd%0d_ovr", it), 32'(bus.overrun), 32'(model_ovr));
      npop = $urandom_range(model_q.size(), 0);
      for (int k = 0; k < npop; k++) pop_check($sformatf("rnd%0d_pop%0d", it, k), model_q.pop_front());
      check($sformatf("rnd%0d_valid", it), 32'(bus.rx_valid), 32'(model_q.size() != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
